// File: rtl/mouse_pos_tracker.sv
// mouse_pos_tracker: assembles 3-byte PS/2 mouse packets into an absolute,
// clamped cursor position plus button levels.
//
// Ports:
//   pclk        in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   rx_data     in   [7:0] byte from the PS/2 byte receiver
//   rx_valid    in   one-cycle strobe qualifying rx_data
//   mouse_xpos  out  [11:0] absolute X (0..MAX_X)
//   mouse_ypos  out  [11:0] absolute Y (0..MAX_Y), 0 = top of screen
//   mouse_left  out  left button level
//   mouse_right out  right button level
//   pkt_done    out  one-cycle strobe, outputs just updated from a packet
//   sync_err    out  one-cycle strobe, byte discarded or packet aborted
module mouse_pos_tracker #(
    parameter int unsigned MAX_X   = 799,
    parameter int unsigned MAX_Y   = 599,
    parameter int unsigned X_INIT  = 400,
    parameter int unsigned Y_INIT  = 300,
    parameter int unsigned TIMEOUT = 40000
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [11:0] mouse_xpos,
    output logic [11:0] mouse_ypos,
    output logic        mouse_left,
    output logic        mouse_right,
    output logic        pkt_done,
    output logic        sync_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic signed [13:0] MAX_X_S  = 14'(MAX_X);
    localparam logic signed [13:0] MAX_Y_S  = 14'(MAX_Y);

    typedef enum logic [1:0] {
        WAIT_B0 = 2'd0,
        WAIT_B1 = 2'd1,
        WAIT_B2 = 2'd2,
        UPDATE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        b0_q, b0_d;
    logic [7:0]        b1_q, b1_d;
    logic [7:0]        b2_q, b2_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [11:0]       xpos_q, xpos_d;
    logic [11:0]       ypos_q, ypos_d;
    logic              left_q, left_d;
    logic              right_q, right_d;
    logic              pkt_done_q, pkt_done_d;
    logic              sync_err_q, sync_err_d;

    logic signed [13:0] dx, dy, x_sum, y_sum;
    logic [11:0]        x_new, y_new;
    logic               timeout_hit;

    // Signed position update with clamping to the visible area
    always_comb begin
        dx    = 14'($signed({b0_q[4], b1_q}));
        dy    = 14'($signed({b0_q[5], b2_q}));
        x_sum = $signed({2'b00, xpos_q}) + dx;
        // PS/2 reports +Y as up while screen Y grows downward
        y_sum = $signed({2'b00, ypos_q}) - dy;

        if (x_sum < 14'sd0) begin
            x_new = 12'd0;
        end else if (x_sum > MAX_X_S) begin
            x_new = 12'(MAX_X);
        end else begin
            x_new = x_sum[11:0];
        end

        if (y_sum < 14'sd0) begin
            y_new = 12'd0;
        end else if (y_sum > MAX_Y_S) begin
            y_new = 12'(MAX_Y);
        end else begin
            y_new = y_sum[11:0];
        end
    end

    assign timeout_hit = (cnt_q >= CNT_LAST);

    // Packet framing FSM, inter-byte timeout and output update
    always_comb begin
        state_d    = state_q;
        b0_d       = b0_q;
        b1_d       = b1_q;
        b2_d       = b2_q;
        cnt_d      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        xpos_d     = xpos_q;
        ypos_d     = ypos_q;
        left_d     = left_q;
        right_d    = right_q;
        pkt_done_d = 1'b0;
        sync_err_d = 1'b0;

        case (state_q)
            WAIT_B0: begin
                if (rx_valid) begin
                    // bit3 is always set in a genuine first byte
                    if (rx_data[3]) begin
                        b0_d    = rx_data;
                        cnt_d   = '0;
                        state_d = WAIT_B1;
                    end else begin
                        sync_err_d = 1'b1;
                    end
                end
            end
            WAIT_B1: begin
                // a byte arriving on the timeout cycle still wins
                if (rx_valid) begin
                    b1_d    = rx_data;
                    cnt_d   = '0;
                    state_d = WAIT_B2;
                end else if (timeout_hit) begin
                    sync_err_d = 1'b1;
                    state_d    = WAIT_B0;
                end
            end
            WAIT_B2: begin
                if (rx_valid) begin
                    b2_d    = rx_data;
                    cnt_d   = '0;
                    state_d = UPDATE;
                end else if (timeout_hit) begin
                    sync_err_d = 1'b1;
                    state_d    = WAIT_B0;
                end
            end
            UPDATE: begin
                // any rx_valid here is silently dropped
                pkt_done_d = 1'b1;
                left_d     = b0_q[0];
                right_d    = b0_q[1];
                if (!b0_q[6]) begin
                    xpos_d = x_new;
                end
                if (!b0_q[7]) begin
                    ypos_d = y_new;
                end
                state_d = WAIT_B0;
            end
            default: begin
                state_d = WAIT_B0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q    <= WAIT_B0;
            b0_q       <= '0;
            b1_q       <= '0;
            b2_q       <= '0;
            cnt_q      <= '0;
            xpos_q     <= 12'(X_INIT);
            ypos_q     <= 12'(Y_INIT);
            left_q     <= 1'b0;
            right_q    <= 1'b0;
            pkt_done_q <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            b0_q       <= b0_d;
            b1_q       <= b1_d;
            b2_q       <= b2_d;
            cnt_q      <= cnt_d;
            xpos_q     <= xpos_d;
            ypos_q     <= ypos_d;
            left_q     <= left_d;
            right_q    <= right_d;
            pkt_done_q <= pkt_done_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign mouse_xpos  = xpos_q;
    assign mouse_ypos  = ypos_q;
    assign mouse_left  = left_q;
    assign mouse_right = right_q;
    assign pkt_done    = pkt_done_q;
    assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_mouse_pos_tracker.sv
// Scoreboard bench for mouse_pos_tracker: the stimulus process feeds bytes
// and pushes expected events; a monitor pops them on pkt_done/sync_err.
module tb_mouse_pos_tracker;

    localparam int TIMEOUT = 64;
    localparam int MAX_X   = 799;
    localparam int MAX_Y   = 599;
    localparam int X_INIT  = 400;
    localparam int Y_INIT  = 300;

    logic        pclk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [11:0] mouse_xpos, mouse_ypos;
    logic        mouse_left, mouse_right, pkt_done, sync_err;

    mouse_pos_tracker #(
        .MAX_X(MAX_X), .MAX_Y(MAX_Y), .X_INIT(X_INIT), .Y_INIT(Y_INIT),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .pclk(pclk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos),
        .mouse_left(mouse_left), .mouse_right(mouse_right),
        .pkt_done(pkt_done), .sync_err(sync_err)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    typedef struct {
        bit is_err;
        int x;
        int y;
        bit l;
        bit r;
        int dmin;
        int dmax;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_pass   = 0;

    // reference model state (stimulus side)
    int model_x = X_INIT;
    int model_y = Y_INIT;

    // last expected visible outputs (monitor side)
    int exp_x = X_INIT;
    int exp_y = Y_INIT;
    bit exp_l = 1'b0;
    bit exp_r = 1'b0;
    exp_t mon_e;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    endtask

    function automatic int clampi(input int v, input int mx);
        if (v < 0) return 0;
        if (v > mx) return mx;
        return v;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    // Returns at the cycle whose opening edge accepted the byte
    task automatic send(input logic [7:0] b, input int gap);
        idle(gap);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge pclk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic packet(input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input int g0, input int g1,
                          input int g2);
        int dx, dy;
        exp_t e;
        send(b0, g0);
        send(b1, g1);
        send(b2, g2);
        dx = b0[4] ? int'(b1) - 256 : int'(b1);
        dy = b0[5] ? int'(b2) - 256 : int'(b2);
        if (!b0[6]) model_x = clampi(model_x + dx, MAX_X);
        if (!b0[7]) model_y = clampi(model_y - dy, MAX_Y);
        e.is_err = 1'b0;
        e.x = model_x;
        e.y = model_y;
        e.l = b0[0];
        e.r = b0[1];
        e.dmin = cyc + 1;
        e.dmax = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic bad(input logic [7:0] b, input int gap);
        exp_t e;
        send(b, gap);
        e.is_err = 1'b1;
        e.x = model_x;
        e.y = model_y;
        e.l = 1'b0;
        e.r = 1'b0;
        e.dmin = cyc;
        e.dmax = cyc;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        rst = 1'b1;
        sb.delete();
        model_x = X_INIT;
        model_y = Y_INIT;
        idle(2);
        rst = 1'b0;
    endtask

    // Monitor: pops the scoreboard on each DUT event, checks outputs every cycle
    always @(negedge pclk) begin
        if (rst) begin
            exp_x = X_INIT;
            exp_y = Y_INIT;
            exp_l = 1'b0;
            exp_r = 1'b0;
        end else begin
            chk("pkt_done_and_sync_err", int'(pkt_done & sync_err), 0);
            if (pkt_done || sync_err) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_event: pkt_done=%0b sync_err=%0b, none expected (cycle %0d)",
                             pkt_done, sync_err, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    chk("event_kind_sync_err", int'(sync_err), int'(mon_e.is_err));
                    n_checks++;
                    if (cyc >= mon_e.dmin && cyc <= mon_e.dmax) n_pass++;
                    else $display("FAIL event_latency: at cycle %0d expected %0d..%0d",
                                  cyc, mon_e.dmin, mon_e.dmax);
                    if (!mon_e.is_err) begin
                        exp_x = mon_e.x;
                        exp_y = mon_e.y;
                        exp_l = mon_e.l;
                        exp_r = mon_e.r;
                    end
                end
            end else if (sb.size() > 0 && cyc > sb[0].dmax) begin
                n_checks++;
                $display("FAIL missing_event: is_err=%0b due by cycle %0d, now %0d",
                         sb[0].is_err, sb[0].dmax, cyc);
                void'(sb.pop_front());
            end
            chk("xpos", int'(mouse_xpos), exp_x);
            chk("ypos", int'(mouse_ypos), exp_y);
            chk("left", int'(mouse_left), int'(exp_l));
            chk("right", int'(mouse_right), int'(exp_r));
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   t_last;
        repeat (3) @(posedge pclk);
        #1;
        rst = 1'b0;
        idle(1);
        chk("reset_xpos", int'(mouse_xpos), 400);
        chk("reset_ypos", int'(mouse_ypos), 300);

        // basic packet from reset
        packet(8'h09, 8'h0A, 8'h05, 1, 0, 0);
        idle(2);
        chk("basic_x", int'(mouse_xpos), 410);
        chk("basic_y", int'(mouse_ypos), 295);
        chk("basic_left", int'(mouse_left), 1);
        chk("basic_right", int'(mouse_right), 0);

        // -256 twice clamps at 0
        do_reset();
        packet(8'h18, 8'h00, 8'h00, 1, 0, 0);
        idle(2);
        chk("neg256_x1", int'(mouse_xpos), 144);
        packet(8'h18, 8'h00, 8'h00, 2, 1, 1);
        idle(2);
        chk("neg256_x2", int'(mouse_xpos), 0);
        chk("neg256_y", int'(mouse_ypos), 300);

        // walk to (790,590) then clamp both at the max
        do_reset();
        packet(8'h28, 8'hFF, 8'h00, 1, 0, 0);
        packet(8'h28, 8'h87, 8'hDE, 1, 1, 0);
        idle(2);
        chk("walk_x", int'(mouse_xpos), 790);
        chk("walk_y", int'(mouse_ypos), 590);
        packet(8'h28, 8'h14, 8'hF0, 1, 0, 0);
        idle(2);
        chk("maxclamp_x", int'(mouse_xpos), 799);
        chk("maxclamp_y", int'(mouse_ypos), 599);

        // bad first byte, then a normal packet
        do_reset();
        bad(8'h00, 1);
        packet(8'h08, 8'h01, 8'h01, 2, 0, 0);
        idle(2);
        chk("resync_x", int'(mouse_xpos), 401);
        chk("resync_y", int'(mouse_ypos), 299);

        // inter-byte timeout aborts a partial packet
        send(8'h08, 1);
        send(8'h05, 0);
        t_last = cyc;
        e.is_err = 1'b1; e.x = 0; e.y = 0; e.l = 1'b0; e.r = 1'b0;
        e.dmin = t_last + TIMEOUT - 1;
        e.dmax = t_last + TIMEOUT + 1;
        sb.push_back(e);
        idle(TIMEOUT + 4);
        chk("timeout_x_held", int'(mouse_xpos), 401);
        chk("timeout_y_held", int'(mouse_ypos), 299);
        packet(8'h08, 8'h01, 8'h00, 1, 0, 0);
        idle(2);
        chk("after_timeout_x", int'(mouse_xpos), 402);

        // gaps just short of the timeout still complete the packet
        packet(8'h08, 8'h02, 8'h00, 1, TIMEOUT - 8, TIMEOUT - 8);

        // byte landing in UPDATE is dropped without error
        packet(8'h0A, 8'h03, 8'h03, 1, 0, 0);
        send(8'h08, 0);
        packet(8'h08, 8'h01, 8'hFF, 1, 0, 0);

        // X overflow holds X, Y and buttons still update
        do_reset();
        packet(8'h49, 8'h7F, 8'h02, 1, 0, 0);
        idle(2);
        chk("xovf_x", int'(mouse_xpos), 400);
        chk("xovf_y", int'(mouse_ypos), 298);
        chk("xovf_left", int'(mouse_left), 1);

        // reset between byte1 and byte2 discards the packet
        send(8'h49, 1);
        send(8'h7F, 0);
        do_reset();
        chk("midrst_x", int'(mouse_xpos), 400);
        chk("midrst_y", int'(mouse_ypos), 300);
        bad(8'h02, 0);
        idle(3);

        // randomized traffic against the reference model
        for (int i = 0; i < 300; i++) begin
            int sel;
            sel = int'($urandom_range(0, 39));
            if (sel == 0) begin
                do_reset();
            end else if (sel < 6) begin
                bad(8'($urandom) & 8'hF7, int'($urandom_range(1, 3)));
            end else begin
                packet(8'($urandom) | 8'h08, 8'($urandom), 8'($urandom),
                       int'($urandom_range(1, 3)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 3)));
            end
        end

        idle(5);
        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mouse_pos_tracker.md
MOUSE_POS_TRACKER -- requirements
Module: mouse_pos_tracker

Interface
REQ-001 Parameter MAX_X, default 799, largest legal mouse_xpos.
REQ-002 Parameter MAX_Y, default 599, largest legal mouse_ypos.
REQ-003 Parameter X_INIT, default 400, mouse_xpos after reset.
REQ-004 Parameter Y_INIT, default 300, mouse_ypos after reset.
REQ-005 Parameter TIMEOUT, default 40000, inter-byte timeout in pclk cycles (1 ms at 40 MHz).
REQ-006 pclk  in  1  system clock, all logic on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 rx_data  in  8  PS/2 mouse byte from the byte receiver.
REQ-009 rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle.
REQ-010 mouse_xpos  out  12  absolute X, unsigned, registered.
REQ-011 mouse_ypos  out  12  absolute Y, unsigned, 0 = top of screen, registered.
REQ-012 mouse_left  out  1  left button level, registered.
REQ-013 mouse_right  out  1  right button level, registered.
REQ-014 pkt_done  out  1  one-cycle strobe; outputs just updated from a complete packet.
REQ-015 sync_err  out  1  one-cycle strobe; byte discarded or packet aborted.

Function
REQ-016 States: WAIT_B0, WAIT_B1, WAIT_B2, UPDATE; reset state WAIT_B0.
REQ-017 WAIT_B0 + rx_valid + rx_data[3]=1 -> latch byte0, go WAIT_B1.
REQ-018 WAIT_B0 + rx_valid + rx_data[3]=0 -> discard byte, pulse sync_err next cycle, stay WAIT_B0.
REQ-019 WAIT_B1 + rx_valid -> latch byte1 (dX low), go WAIT_B2.
REQ-020 WAIT_B2 + rx_valid -> latch byte2 (dY low), go UPDATE.
REQ-021 UPDATE lasts exactly one cycle, then WAIT_B0; rx_valid during UPDATE is dropped without sync_err.
REQ-022 Byte0 fields: bit0 left, bit1 right, bit4 X sign, bit5 Y sign, bit6 X overflow, bit7 Y overflow.
REQ-023 dX = 9-bit two's complement {byte0[4], byte1}; dY = {byte0[5], byte2}; range -256..+255.
REQ-024 New X = mouse_xpos + dX; new Y = mouse_ypos - dY (PS/2 +Y is up); signed intermediates of at least 14 bits.
REQ-025 Result < 0 clamps to 0; X > MAX_X clamps to MAX_X; Y > MAX_Y clamps to MAX_Y.
REQ-026 Axis overflow bit set -> that axis keeps its position; other axis and buttons still update.
REQ-027 Outputs load at the clock edge ending UPDATE; pkt_done is high for exactly the first cycle the new values are visible.
REQ-028 Latency: byte2 accepted at edge N -> outputs and pkt_done change at edge N+1.
REQ-029 Outputs hold their values between packets; a partial or aborted packet never changes them.
REQ-030 Timeout counter clears on every accepted byte and counts in WAIT_B1/WAIT_B2; at TIMEOUT -> WAIT_B0, sync_err pulse, partial packet discarded.
REQ-031 Counter saturates and is ignored in WAIT_B0 and UPDATE.
REQ-032 Timeout and rx_valid in the same cycle: the byte wins and the counter clears.
REQ-033 sync_err and pkt_done are never high in the same cycle.

Reset
REQ-034 rst high at an edge: state WAIT_B0, mouse_xpos=X_INIT, mouse_ypos=Y_INIT, mouse_left=0, mouse_right=0, pkt_done=0, sync_err=0, timeout counter 0.
REQ-035 rst overrides everything, including mid-packet and UPDATE; latched bytes are discarded.
REQ-036 The first byte after rst deasserts is treated as a byte0 candidate.

Verification
REQ-037 After reset, bytes 0x09, 0x0A, 0x05 -> xpos 410, ypos 295, left=1, right=0, pkt_done one cycle, one cycle after byte 3.
REQ-038 From (400,300), bytes 0x18, 0x00, 0x00 (dX=-256) twice -> xpos 144 then 0 (clamped); ypos stays 300.
REQ-039 From (790,590), bytes 0x28, 0x14, 0xF0 (dX=+20, dY=-16) -> xpos 799, ypos 599 (both clamped).
REQ-040 Byte 0x00 in WAIT_B0 -> sync_err one cycle, no state change; then 0x08,0x01,0x01 -> xpos+1, ypos-1.
REQ-041 Bytes 0x08, 0x05, then no byte for TIMEOUT cycles -> sync_err, outputs unchanged; next 0x08,0x01,0x00 gives xpos+1.
REQ-042 Byte 0x49 (X overflow), 0x7F, 0x02 -> xpos unchanged, ypos-2, left=1; also rst asserted between byte1 and byte2 -> outputs return to (400,300), no pkt_done.
